commit_trace_monitor: RTL and testbench
=======================================

Name: commit_trace_monitor

Overview:
- Consumer end of the CPU core's retirement interface: samples the write-back-stage commit stream (commit, commit_instr, commit_pc, commit_pre_pc) every cycle.
- Buffers each retired instruction as a sequence-numbered trace record in a FIFO and drains records over a valid/ready stream to the debug/trace port.
- Also maintains instret and cycle counters, plus a no-commit watchdog that flags a hung pipeline.
- Sits beside the CPU top level in the SoC/testbench shell.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- TIMEOUT, 1024, consecutive cycles without a commit (after the first commit) that declare a hang; must be at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- commit  input  1  a retirement occurs this cycle.
- commit_instr  input  32  retired instruction word.
- commit_pc  input  64  retired instruction PC.
- commit_pre_pc  input  64  predicted next PC recorded at fetch.
- out_valid  output  1  trace record available.
- out_ready  input  1  sink accepts the record.
- out_seq  output  32  record sequence number.
- out_pc  output  64  record PC.
- out_pre_pc  output  64  record predicted next PC.
- out_instr  output  32  record instruction word.
- instret  output  64  count of retired instructions.
- cycles  output  64  cycles since reset release.
- drop_cnt  output  16  records lost to a full FIFO (saturating).
- overflow  output  1  sticky; at least one record dropped.
- hang  output  1  sticky watchdog flag.

Behaviour:
- Reset: asserting rst immediately clears all state asynchronously, including mid-stream or with the FIFO full.
  - Outputs during reset: out_valid=0, out_* data=0, instret=0, cycles=0, drop_cnt=0, overflow=0, hang=0, seq counter=0, FIFO empty, FSM=WAIT_FIRST.
  - Records pending at reset are discarded.
- Cycle counter: cycles increments by 1 every clock edge after reset and wraps at 2^64.
- Capture:
  - On a rising edge with commit=1, the record {seq, commit_pc, commit_pre_pc, commit_instr} is pushed, then seq increments.
  - seq wraps from 0xFFFFFFFF to 0.
  - instret increments on every commit, whether the record is pushed or dropped.
- Latency: a record pushed at edge N drives out_valid=1 at edge N at the earliest. There is no combinational bypass from commit to out_*.
- Stream handshake:
  - A record transfers on an edge where out_valid && out_ready.
  - out_* data stays stable while out_valid=1 and out_ready=0.
  - out_* data is 0 whenever out_valid=0.
- FIFO full:
  - A push is accepted if count<DEPTH, or if a pop occurs on the same edge.
  - Otherwise the record is dropped: drop_cnt increments (saturating at 0xFFFF), overflow is set, and seq still increments, so the sink observes a gap.
- Simultaneous push and pop on an empty FIFO: no pop occurs (out_valid=0); the push is accepted.
- Pointers: log2(DEPTH)-bit read/write pointers wrap naturally; the count is log2(DEPTH)+1 bits wide.
- FSM (watchdog):
  - WAIT_FIRST: watchdog idle. On commit, go to RUN with wd=0.
  - RUN: wd=0 on commit, else wd+1. When wd reaches TIMEOUT-1 with no commit, go to HUNG.
  - HUNG: hang=1 is sticky. Capture continues, and a commit in HUNG does not clear hang. Only reset exits HUNG.
- hang rises on the edge where the TIMEOUT-th consecutive idle cycle completes.

Optional Feature:
- Macro: COMMIT_TRACE_EBREAK_HALT_EN.
- When defined:
  - Adds output halted (1 bit, reset 0) and FSM state HALTED.
  - A commit with commit_instr==32'h00100073 (ebreak) is captured normally, then the FSM enters HALTED and sets halted=1.
  - In HALTED, later commits are ignored: no push, no instret increment, no seq increment. The watchdog is frozen. The FIFO keeps draining.
  - HALTED has priority over HUNG; an ebreak commit while in HUNG still moves the FSM to HALTED.
- When undefined: no halted port, and ebreak is treated like any other instruction.

Decomposition:
- Package commit_trace_pkg holds:
  - The trace record struct {seq[31:0], pc[63:0], pre_pc[63:0], instr[31:0]} (192 bits).
  - The FSM state enum {WAIT_FIRST, RUN, HUNG, HALTED}.
  - The constant EBREAK_INSTR = 32'h00100073.
- One sub-module, commit_trace_fifo: a parameterised synchronous FIFO of records with push/pop/full/empty/count.
- The top level keeps the counters, the watchdog FSM and the drop logic.

Test Plan:
- Basic capture: three commits at pc 0x80000000/0x80000004/0x80000008 with out_ready=1 -> three records with out_seq 0,1,2 in order; instret=3; drop_cnt=0.
- Backpressure and overflow: out_ready=0, DEPTH=8, 10 back-to-back commits -> FIFO holds seq 0..7; drop_cnt=2; overflow=1; instret=10. Then release out_ready -> seq 0..7 drain with data stable while stalled.
- Full with simultaneous pop: FIFO full, commit and out_ready=1 on the same edge -> pop of seq 0, new record accepted, drop_cnt unchanged, count stays 8.
- Watchdog: TIMEOUT=16, one commit, then 15 idle cycles -> hang=0; one more idle cycle -> hang=1. A further commit leaves hang=1.
- Reset mid-operation: assert rst with 5 records queued and hang=1 -> out_valid, hang, instret, cycles and drop_cnt are 0 immediately (asynchronously); the next commit after release gets out_seq 0.
- COMMIT_TRACE_EBREAK_HALT_EN: commit 0x00100073 then two more commits -> only the ebreak record is pushed; halted=1; instret unchanged by the later commits.

Source files
------------

// File: rtl/commit_trace_pkg.sv
// Shared types for the commit trace monitor: trace record, watchdog state, ebreak encoding.
package commit_trace_pkg;

  localparam logic [31:0] EBREAK_INSTR = 32'h00100073;

  typedef struct packed {
    logic [31:0] seq;
    logic [63:0] pc;
    logic [63:0] pre_pc;
    logic [31:0] instr;
  } trace_rec_t;

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    RUN        = 2'd1,
    HUNG       = 2'd2,
    HALTED     = 2'd3
  } fsm_state_e;

endpackage

// File: rtl/commit_trace_monitor_if.sv
// Commit stream in, trace stream and status out. slave = monitor, master = core/sink side.
// The halted signal exists only with COMMIT_TRACE_EBREAK_HALT_EN.
interface commit_trace_monitor_if;
  logic        commit;
  logic [31:0] commit_instr;
  logic [63:0] commit_pc;
  logic [63:0] commit_pre_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_seq;
  logic [63:0] out_pc;
  logic [63:0] out_pre_pc;
  logic [31:0] out_instr;
  logic [63:0] instret;
  logic [63:0] cycles;
  logic [15:0] drop_cnt;
  logic        overflow;
  logic        hang;
`ifdef COMMIT_TRACE_EBREAK_HALT_EN
  logic        halted;
`endif

  modport slave (
`ifdef COMMIT_TRACE_EBREAK_HALT_EN
    output halted,
`endif
    input  commit, commit_instr, commit_pc, commit_pre_pc, out_ready,
    output out_valid, out_seq, out_pc, out_pre_pc, out_instr,
    output instret, cycles, drop_cnt, overflow, hang
  );

  modport master (
`ifdef COMMIT_TRACE_EBREAK_HALT_EN
    input  halted,
`endif
    output commit, commit_instr, commit_pc, commit_pre_pc, out_ready,
    input  out_valid, out_seq, out_pc, out_pre_pc, out_instr,
    input  instret, cycles, drop_cnt, overflow, hang
  );
endinterface

// File: rtl/commit_trace_fifo.sv
// Synchronous record FIFO; pointers wrap naturally since DEPTH is a power of two.
module commit_trace_fifo
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  trace_rec_t               wr_data,
  input  logic                     pop,
  output trace_rec_t               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  trace_rec_t    mem_q [DEPTH];
  trace_rec_t    mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      mem_d[wptr_q] = wr_data;
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop) rptr_d = rptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rd_data = mem_q[rptr_q];
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign count   = cnt_q;
endmodule

// File: rtl/commit_trace_monitor.sv
// Retirement trace monitor: sequence-numbered record FIFO, instret/cycle counters, no-commit watchdog.
// Optional COMMIT_TRACE_EBREAK_HALT_EN adds an ebreak-triggered HALTED state and halted output.
module commit_trace_monitor
  import commit_trace_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  commit_trace_monitor_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT);

  localparam logic [1:0] S_WAIT_FIRST = WAIT_FIRST;
  localparam logic [1:0] S_RUN        = RUN;
  localparam logic [1:0] S_HUNG       = HUNG;
  localparam logic [1:0] S_HALTED     = HALTED;

  logic [31:0]   seq_q, seq_d;
  logic [63:0]   instret_q, instret_d, cycles_q, cycles_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic          overflow_q, overflow_d, hang_q, hang_d;
  logic [1:0]    state_q, state_d;
  logic [WW-1:0] wd_q, wd_d;

  logic          cap, push, pop, drop, out_valid;
  logic          fifo_full, fifo_empty;
  logic [AW:0]   fifo_cnt;
  trace_rec_t    wr_rec, rd_rec;

`ifdef COMMIT_TRACE_EBREAK_HALT_EN
  assign cap = bus.commit && (state_q != S_HALTED);
`else
  assign cap = bus.commit;
`endif

  // A full FIFO still accepts when the head leaves on the same edge.
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && bus.out_ready;
  assign push      = cap && (!fifo_full || pop);
  assign drop      = cap && !push;
  assign wr_rec    = '{seq: seq_q, pc: bus.commit_pc, pre_pc: bus.commit_pre_pc,
                       instr: bus.commit_instr};

  commit_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (wr_rec),
    .pop     (pop),
    .rd_data (rd_rec),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  always_comb begin
    seq_d      = seq_q;
    instret_d  = instret_q;
    cycles_d   = cycles_q + 64'd1;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    hang_d     = hang_q;
    state_d    = state_q;
    wd_d       = wd_q;
    if (cap) begin
      seq_d     = seq_q + 32'd1;
      instret_d = instret_q + 64'd1;
    end
    if (drop) begin
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      overflow_d = 1'b1;
    end
    case (state_q)
      S_WAIT_FIRST: if (cap) begin
        state_d = S_RUN;
        wd_d    = '0;
      end
      S_RUN: begin
        if (cap) wd_d = '0;
        else if (wd_q == WW'(TIMEOUT - 1)) begin
          state_d = S_HUNG;
          hang_d  = 1'b1;
        end else wd_d = wd_q + WW'(1);
      end
      default: ;
    endcase
`ifdef COMMIT_TRACE_EBREAK_HALT_EN
    if (cap && bus.commit_instr == EBREAK_INSTR) state_d = S_HALTED;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q      <= '0;
      instret_q  <= '0;
      cycles_q   <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
      hang_q     <= 1'b0;
      state_q    <= S_WAIT_FIRST;
      wd_q       <= '0;
    end else begin
      seq_q      <= seq_d;
      instret_q  <= instret_d;
      cycles_q   <= cycles_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
      hang_q     <= hang_d;
      state_q    <= state_d;
      wd_q       <= wd_d;
    end
  end

  assert property (@(posedge clk) disable iff (rst) fifo_cnt <= (AW+1)'(DEPTH));

  assign bus.out_valid  = out_valid;
  assign bus.out_seq    = out_valid ? rd_rec.seq    : '0;
  assign bus.out_pc     = out_valid ? rd_rec.pc     : '0;
  assign bus.out_pre_pc = out_valid ? rd_rec.pre_pc : '0;
  assign bus.out_instr  = out_valid ? rd_rec.instr  : '0;
  assign bus.instret    = instret_q;
  assign bus.cycles     = cycles_q;
  assign bus.drop_cnt   = drop_cnt_q;
  assign bus.overflow   = overflow_q;
  assign bus.hang       = hang_q;
`ifdef COMMIT_TRACE_EBREAK_HALT_EN
  assign bus.halted     = (state_q == S_HALTED);
`endif
endmodule

// File: tb/tb_commit_trace_monitor.sv
// Self-checking bench for commit_trace_monitor (DEPTH=8, TIMEOUT=16) against a queue-based model.
module tb_commit_trace_monitor;
  import commit_trace_pkg::*;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  commit_trace_monitor_if vif ();
  commit_trace_monitor #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: a queue of records plus plain counters.
  trace_rec_t  mq[$];
  logic [31:0] m_seq;
  logic [63:0] m_instret, m_cycles;
  int          m_drop, m_idle;
  bit          m_ovf, m_hang, m_started, m_halted;

  function automatic void model_reset();
    mq.delete();
    m_seq = 0; m_instret = 0; m_cycles = 0; m_drop = 0; m_idle = 0;
    m_ovf = 0; m_hang = 0; m_started = 0; m_halted = 0;
  endfunction

  function automatic void model_step(input bit c, input logic [31:0] ins,
                                     input logic [63:0] p, input logic [63:0] pp, input bit rdy);
    bit cap;
    trace_rec_t r;
    m_cycles++;
    if (mq.size() > 0 && rdy) void'(mq.pop_front());
    cap = c && !m_halted;
    if (cap) begin
      r.seq = m_seq; r.pc = p; r.pre_pc = pp; r.instr = ins;
      if (mq.size() < DEPTH) mq.push_back(r);
      else begin
        if (m_drop < 65535) m_drop++;
        m_ovf = 1;
      end
      m_seq++;
      m_instret++;
    end
    if (!m_halted) begin
      if (cap) begin m_started = 1; m_idle = 0; end
      else if (m_started) begin
        m_idle++;
        if (m_idle >= TIMEOUT) m_hang = 1;
      end
    end
`ifdef COMMIT_TRACE_EBREAK_HALT_EN
    if (cap && ins == EBREAK_INSTR) m_halted = 1;
`endif
  endfunction

  // Drive one cycle's inputs from a negedge, advance to the next negedge.
  task automatic tick(input bit c, input logic [31:0] ins, input logic [63:0] p,
                      input logic [63:0] pp, input bit rdy);
    vif.commit = c; vif.commit_instr = ins; vif.commit_pc = p;
    vif.commit_pre_pc = pp; vif.out_ready = rdy;
    @(posedge clk);
    model_step(c, ins, p, pp, rdy);
    @(negedge clk);
  endtask

  task automatic commit_n(input int n, input bit rdy);
    for (int i = 0; i < n; i++)
      tick(1, 32'h13 + 32'(i << 7), 64'h8000_0000 + 64'(4 * i), 64'h8000_0004 + 64'(4 * i), rdy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vif.commit = 0; vif.commit_instr = 0; vif.commit_pc = 0; vif.commit_pre_pc = 0;
    vif.out_ready = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vif.commit = 0; vif.commit_instr = 0; vif.commit_pc = 0; vif.commit_pre_pc = 0;
    vif.out_ready = 0;
    repeat (2) @(negedge clk);
    checks++; if (vif.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", vif.out_valid); end
    checks++; if ({vif.out_seq, vif.out_pc, vif.out_pre_pc, vif.out_instr} !== 192'd0) begin failures++; $display("FAIL reset_data got=%0h exp=0", vif.out_pc); end
    checks++; if ({vif.instret, vif.cycles} !== 128'd0) begin failures++; $display("FAIL reset_cnt got=%0h/%0h exp=0", vif.instret, vif.cycles); end
    checks++; if ({vif.drop_cnt, vif.overflow, vif.hang} !== 18'd0) begin failures++; $display("FAIL reset_flags got=%0h exp=0", {vif.drop_cnt, vif.overflow, vif.hang}); end
    rst = 1'b0;
    model_reset();
    tick(0, 0, 0, 0, 0);
    checks++; if (vif.cycles !== 64'd1) begin failures++; $display("FAIL first_cycle got=%0d exp=1", vif.cycles); end
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1, 32'h0000_0013, 64'h8000_0000 + 64'(4 * i), 64'h8000_0004 + 64'(4 * i), 1);
      checks++;
      if (vif.out_valid !== 1'b1 || vif.out_seq !== 32'(i) || vif.out_pc !== 64'h8000_0000 + 64'(4 * i)) begin
        failures++; $display("FAIL basic_rec%0d got=v%0b seq%0d pc%0h", i, vif.out_valid, vif.out_seq, vif.out_pc);
      end
    end
    tick(0, 0, 0, 0, 1);
    checks++; if (vif.out_valid !== 1'b0 || vif.out_pc !== 64'd0) begin failures++; $display("FAIL basic_empty got=v%0b pc%0h exp=v0 pc0", vif.out_valid, vif.out_pc); end
    checks++; if (vif.instret !== 64'd3 || vif.drop_cnt !== 16'd0) begin failures++; $display("FAIL basic_cnt got=%0d/%0d exp=3/0", vif.instret, vif.drop_cnt); end
  endtask

  task automatic test_backpressure();
    logic [191:0] held;
    do_reset();
    commit_n(10, 0);
    checks++; if (vif.drop_cnt !== 16'd2 || vif.overflow !== 1'b1 || vif.instret !== 64'd10) begin
      failures++; $display("FAIL bp_counts got=drop%0d ovf%0b inst%0d exp=2/1/10", vif.drop_cnt, vif.overflow, vif.instret);
    end
    held = {vif.out_seq, vif.out_pc, vif.out_pre_pc, vif.out_instr};
    repeat (3) tick(0, 0, 0, 0, 0);
    checks++; if ({vif.out_seq, vif.out_pc, vif.out_pre_pc, vif.out_instr} !== held || vif.out_seq !== 32'd0) begin
      failures++; $display("FAIL bp_stable got=%0h exp=%0h", {vif.out_seq, vif.out_pc}, held[191:96]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (vif.out_valid !== 1'b1 || vif.out_seq !== 32'(i)) begin
        failures++; $display("FAIL bp_drain%0d got=v%0b seq%0d", i, vif.out_valid, vif.out_seq);
      end
      tick(0, 0, 0, 0, 1);
    end
    checks++; if (vif.out_valid !== 1'b0) begin failures++; $display("FAIL bp_done got=%0b exp=0", vif.out_valid); end
  endtask

  task automatic test_full_pop();
    int n;
    do_reset();
    commit_n(DEPTH, 0);
    tick(1, 32'h0000_0093, 64'h9000_0000, 64'h9000_0004, 1);
    checks++; if (vif.drop_cnt !== 16'd0 || vif.out_seq !== 32'd1) begin
      failures++; $display("FAIL fullpop got=drop%0d seq%0d exp=0/1", vif.drop_cnt, vif.out_seq);
    end
    n = 0;
    for (int i = 0; i < 20 && vif.out_valid === 1'b1; i++) begin
      checks++; if (vif.out_seq !== 32'(n + 1)) begin failures++; $display("FAIL fullpop_seq got=%0d exp=%0d", vif.out_seq, n + 1); end
      n++;
      tick(0, 0, 0, 0, 1);
    end
    checks++; if (n !== DEPTH) begin failures++; $display("FAIL fullpop_count got=%0d exp=%0d", n, DEPTH); end
  endtask

  task automatic test_watchdog();
    do_reset();
    commit_n(1, 1);
    repeat (TIMEOUT - 1) tick(0, 0, 0, 0, 1);
    checks++; if (vif.hang !== 1'b0) begin failures++; $display("FAIL wd_early got=%0b exp=0", vif.hang); end
    tick(0, 0, 0, 0, 1);
    checks++; if (vif.hang !== 1'b1) begin failures++; $display("FAIL wd_fire got=%0b exp=1", vif.hang); end
    commit_n(1, 1);
    checks++; if (vif.hang !== 1'b1) begin failures++; $display("FAIL wd_sticky got=%0b exp=1", vif.hang); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    commit_n(1, 1);
    repeat (TIMEOUT) tick(0, 0, 0, 0, 1);
    commit_n(5, 0);
    checks++; if (vif.hang !== 1'b1 || vif.out_valid !== 1'b1) begin failures++; $display("FAIL mid_setup got=h%0b v%0b exp=1/1", vif.hang, vif.out_valid); end
    rst = 1'b1;
    #1;
    checks++; if ({vif.out_valid, vif.hang, vif.overflow} !== 3'b000 || vif.out_seq !== 32'd0) begin
      failures++; $display("FAIL mid_async_flags got=%0b seq%0d exp=0", {vif.out_valid, vif.hang, vif.overflow}, vif.out_seq);
    end
    checks++; if (vif.instret !== 64'd0 || vif.cycles !== 64'd0 || vif.drop_cnt !== 16'd0) begin
      failures++; $display("FAIL mid_async_cnt got=%0d/%0d/%0d exp=0", vif.instret, vif.cycles, vif.drop_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tick(1, 32'h0000_0113, 64'hA000_0000, 64'hA000_0004, 0);
    checks++; if (vif.out_valid !== 1'b1 || vif.out_seq !== 32'd0 || vif.out_pc !== 64'hA000_0000) begin
      failures++; $display("FAIL mid_restart got=v%0b seq%0d pc%0h", vif.out_valid, vif.out_seq, vif.out_pc);
    end
  endtask

  task automatic test_random();
    int pc_pct, rdy_pct;
    logic [31:0] ins;
    logic [191:0] exp_d;
    do_reset();
    for (int cyc = 0; cyc < 900; cyc++) begin
      case (cyc / 150)
        0, 3:    begin pc_pct = 85; rdy_pct = 25; end
        1, 4:    begin pc_pct = 30; rdy_pct = 90; end
        default: begin pc_pct = 2;  rdy_pct = 60; end
      endcase
      ins = $urandom;
      if (ins == EBREAK_INSTR) ins = ins ^ 32'h1;
      tick($urandom_range(99) < pc_pct, ins, {$urandom, $urandom}, {$urandom, $urandom},
           $urandom_range(99) < rdy_pct);
      exp_d = (mq.size() > 0) ? {mq[0].seq, mq[0].pc, mq[0].pre_pc, mq[0].instr} : 192'd0;
      checks++; if (vif.out_valid !== (mq.size() > 0)) begin failures++; $display("FAIL rnd_valid@%0d got=%0b exp=%0b", cyc, vif.out_valid, mq.size() > 0); end
      checks++; if ({vif.out_seq, vif.out_pc, vif.out_pre_pc, vif.out_instr} !== exp_d) begin
        failures++; $display("FAIL rnd_data@%0d got=%0h exp=%0h", cyc, {vif.out_seq, vif.out_pc, vif.out_pre_pc, vif.out_instr}, exp_d);
      end
      checks++; if (vif.instret !== m_instret || vif.cycles !== m_cycles) begin
        failures++; $display("FAIL rnd_cnt@%0d got=%0d/%0d exp=%0d/%0d", cyc, vif.instret, vif.cycles, m_instret, m_cycles);
      end
      checks++; if (vif.drop_cnt !== 16'(m_drop) || vif.overflow !== m_ovf || vif.hang !== m_hang) begin
        failures++; $display("FAIL rnd_flags@%0d got=%0d/%0b/%0b exp=%0d/%0b/%0b", cyc, vif.drop_cnt, vif.overflow, vif.hang, m_drop, m_ovf, m_hang);
      end
    end
  endtask

`ifdef COMMIT_TRACE_EBREAK_HALT_EN
  task automatic test_ebreak();
    do_reset();
    checks++; if (vif.halted !== 1'b0) begin failures++; $display("FAIL eb_reset got=%0b exp=0", vif.halted); end
    tick(1, EBREAK_INSTR, 64'hB000_0000, 64'hB000_0004, 0);
    commit_n(2, 0);
    checks++; if (vif.halted !== 1'b1 || vif.instret !== 64'd1) begin
      failures++; $display("FAIL eb_halt got=h%0b inst%0d exp=1/1", vif.halted, vif.instret);
    end
    checks++; if (vif.out_seq !== 32'd0 || vif.out_instr !== EBREAK_INSTR) begin
      failures++; $display("FAIL eb_rec got=seq%0d ins%0h", vif.out_seq, vif.out_instr);
    end
    tick(0, 0, 0, 0, 1);
    checks++; if (vif.out_valid !== 1'b0) begin failures++; $display("FAIL eb_only got=%0b exp=0", vif.out_valid); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_full_pop();
    test_watchdog();
    test_reset_mid();
    test_random();
`ifdef COMMIT_TRACE_EBREAK_HALT_EN
    test_ebreak();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
